alu_acc_seq: RTL and testbench

Accumulator sequencer wrapped around the NBITS-wide combinational ALU. It accepts commands (opcode plus B operand) over a valid/ready handshake and drives the ALU's A, B and OpCode inputs, with the accumulator as operand A. It captures the ALU's Q/C result into the accumulator and flag registers and returns the full (NBITS+1)-bit result over a valid/ready response channel. It sits directly upstream and downstream of the ALU.

---
 rtl/alu_acc_pkg.sv | 26 ++
 rtl/alu_acc_seq_if.sv | 36 +++
 rtl/alu_acc_opcnt.sv | 33 +++
 rtl/alu_acc_seq.sv | 135 +++++++++++++
 tb/tb_alu_acc_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_acc_pkg.sv
// Shared types and constants for the ALU accumulator sequencer: FSM state
// encoding, ALU opcodes and the opcode scrambling used in the SETUP cycle.
package alu_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDC = 3'b010;
    localparam logic [2:0] OP_SUBB = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    // Inverting the opcode guarantees the ALU sees an opcode change before EXEC.
    function automatic logic [2:0] setup_opcode(input logic [2:0] op);
        return ~op;
    endfunction

endpackage

// File: rtl/alu_acc_seq_if.sv
// Command, ALU and response signals of the accumulator sequencer.
// slave = sequencer side, master = command source / ALU / consumer side.
interface alu_acc_seq_if #(
    parameter int NBITS = 4
);
    logic             CmdValid;
    logic             CmdReady;
    logic             CmdLoad;
    logic [2:0]       CmdOp;
    logic [NBITS-1:0] CmdB;
    logic [NBITS-1:0] AluA;
    logic [NBITS-1:0] AluB;
    logic [2:0]       AluOp;
    logic [NBITS:0]   AluQ;
    logic             AluC;
    logic [NBITS-1:0] Acc;
    logic             CarryFlag;
    logic             ZeroFlag;
    logic             RspValid;
    logic             RspReady;
    logic [NBITS:0]   RspQ;
    logic [7:0]       OpCount;

    modport slave (
        input  CmdValid, CmdLoad, CmdOp, CmdB, AluQ, AluC, RspReady,
        output CmdReady, AluA, AluB, AluOp, Acc, CarryFlag, ZeroFlag,
               RspValid, RspQ, OpCount
    );

    modport master (
        output CmdValid, CmdLoad, CmdOp, CmdB, AluQ, AluC, RspReady,
        input  CmdReady, AluA, AluB, AluOp, Acc, CarryFlag, ZeroFlag,
               RspValid, RspQ, OpCount
    );

endinterface

// File: rtl/alu_acc_opcnt.sv
// 8-bit saturating counter of response handshakes; cleared only by reset.
module alu_acc_opcnt (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       inc_i,
    output logic [7:0] count_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: hold at 255 once reached.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 8'd255)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer around an external combinational ALU.
// Optional response counter enabled by defining ALU_ACC_SEQ_STAT_EN.
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    alu_acc_seq_if.slave bus
);

    seq_state_e       state_q, state_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [2:0]       op_q, op_d;
    logic [NBITS:0]   rsp_q_q, rsp_q_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             cmd_fire_s;
    logic             rsp_fire_s;
    logic [7:0]       op_count_s;

    assign cmd_fire_s = bus.CmdValid && cmd_ready_q;
    assign rsp_fire_s = rsp_valid_q && bus.RspReady;

    // Next-state and datapath update for the four-state command sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        op_d     = op_q;
        rsp_q_d  = rsp_q_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire_s) begin
                    if (bus.CmdLoad) begin
                        acc_d   = bus.CmdB;
                        rsp_q_d = {1'b0, bus.CmdB};
                        carry_d = 1'b0;
                        zero_d  = (bus.CmdB == {NBITS{1'b0}});
                        state_d = RESP;
                    end else begin
                        alu_b_d  = bus.CmdB;
                        alu_op_d = setup_opcode(bus.CmdOp);
                        op_d     = bus.CmdOp;
                        state_d  = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                alu_op_d = op_q;
                state_d  = EXEC;
            end
            EXEC: begin
                // ALU output has had the whole EXEC cycle to settle.
                rsp_q_d = bus.AluQ;
                acc_d   = bus.AluQ[NBITS-1:0];
                carry_d = bus.AluC;
                zero_d  = (bus.AluQ[NBITS-1:0] == {NBITS{1'b0}});
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State, datapath and handshake output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            acc_q       <= {NBITS{1'b0}};
            alu_b_q     <= {NBITS{1'b0}};
            alu_op_q    <= 3'b000;
            op_q        <= 3'b000;
            rsp_q_q     <= {(NBITS+1){1'b0}};
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            op_q        <= op_d;
            rsp_q_q     <= rsp_q_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ALU_ACC_SEQ_STAT_EN
    alu_acc_opcnt u_opcnt (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .inc_i   (rsp_fire_s),
        .count_o (op_count_s)
    );
`else
    assign op_count_s = 8'd0;
`endif

    assign bus.CmdReady  = cmd_ready_q;
    assign bus.AluA      = acc_q;
    assign bus.AluB      = alu_b_q;
    assign bus.AluOp     = alu_op_q;
    assign bus.Acc       = acc_q;
    assign bus.CarryFlag = carry_q;
    assign bus.ZeroFlag  = zero_q;
    assign bus.RspValid  = rsp_valid_q;
    assign bus.RspQ      = rsp_q_q;
    assign bus.OpCount   = op_count_s;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq with a behavioural 4-bit ALU attached.
module tb_alu_acc_seq;
    import alu_acc_pkg::*;

    typedef struct packed {
        logic [4:0] q;
        logic [3:0] acc;
        logic       c;
        logic       z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic [2:0] setup_op;
    logic [2:0] exec_op;
    logic [4:0] alu_q;

    alu_acc_seq_if #(.NBITS(4)) bus ();

    alu_acc_seq #(.NBITS(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: Q is the 5-bit result, C its top bit.
    always_comb begin
        case (bus.AluOp)
            OP_ADD:  alu_q = {1'b0, bus.AluA} + {1'b0, bus.AluB};
            OP_SUB:  alu_q = {1'b0, bus.AluA} - {1'b0, bus.AluB};
            OP_ADDC: alu_q = {1'b0, bus.AluA} + {1'b0, bus.AluB} + {4'd0, bus.CarryFlag};
            OP_SUBB: alu_q = {1'b0, bus.AluA} - {1'b0, bus.AluB} - {4'd0, bus.CarryFlag};
            OP_AND:  alu_q = {1'b0, bus.AluA & bus.AluB};
            OP_OR:   alu_q = {1'b0, bus.AluA | bus.AluB};
            OP_XOR:  alu_q = {1'b0, bus.AluA ^ bus.AluB};
            OP_NOT:  alu_q = {1'b0, ~bus.AluA};
            default: alu_q = 5'd0;
        endcase
    end
    assign bus.AluQ = alu_q;
    assign bus.AluC = alu_q[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Monitor: every response handshake is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.RspValid && bus.RspReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got RspQ=%0h with no command outstanding", bus.RspQ);
            end else begin
                exp_t e;
                exp_t g;
                e = exp_q.pop_front();
                g = '{q: bus.RspQ, acc: bus.Acc, c: bus.CarryFlag, z: bus.ZeroFlag};
                if (g !== e) begin
                    failures++;
                    $display("FAIL rsp: got q=%0h acc=%0h c=%0b z=%0b expected q=%0h acc=%0h c=%0b z=%0b",
                             g.q, g.acc, g.c, g.z, e.q, e.acc, e.c, e.z);
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic [4:0] q);
        return '{q: q, acc: q[3:0], c: q[4], z: (q[3:0] == 4'd0)};
    endfunction

    // Issue one command, then measure the cycles until RspValid.
    task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] b,
                        input logic [4:0] q, input int lat);
        int n;
        @(posedge clk); #1;
        bus.CmdValid = 1'b1;
        bus.CmdLoad  = ld;
        bus.CmdOp    = op;
        bus.CmdB     = b;
        n = 0;
        @(negedge clk);
        while (!bus.CmdReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 32'(bus.CmdReady), 32'd1);
        exp_q.push_back(mk_exp(q));
        @(posedge clk); #1;
        bus.CmdValid = 1'b0;
        bus.CmdOp    = ~op;
        bus.CmdB     = ~b;
        bus.CmdLoad  = ~ld;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) setup_op = bus.AluOp;
            if (n == 2) exec_op = bus.AluOp;
        end while (!bus.RspValid && n < 20);
        chk("latency", 32'(n), 32'(lat));
    endtask

    initial begin
        int bad;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.CmdValid = 1'b0;
        bus.CmdLoad  = 1'b0;
        bus.CmdOp    = 3'b000;
        bus.CmdB     = 4'd0;
        bus.RspReady = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.CmdReady), 32'd1);
        chk("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
        chk("rst_acc",       32'(bus.Acc), 32'd0);
        chk("rst_alu",       32'({bus.AluA, bus.AluB, bus.AluOp}), 32'd0);
        chk("rst_rspq",      32'(bus.RspQ), 32'd0);
        chk("rst_flags",     32'({bus.CarryFlag, bus.ZeroFlag}), 32'd0);
        chk("rst_opcount",   32'(bus.OpCount), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(1'b1, 3'b000, 4'hA, 5'h0A, 1);
        send(1'b0, OP_ADD, 4'h7, 5'h11, 3);
        chk("setup_opcode", 32'(setup_op), 32'(3'b111));
        chk("exec_opcode",  32'(exec_op), 32'(3'b000));
        send(1'b1, 3'b000, 4'h5, 5'h05, 1);
        send(1'b0, OP_SUB, 4'h5, 5'h00, 3);
        send(1'b1, 3'b000, 4'h3, 5'h03, 1);
        send(1'b0, OP_SUB, 4'h5, 5'h1E, 3);
        send(1'b0, OP_XOR, 4'h6, 5'h08, 3);
        send(1'b0, OP_AND, 4'hC, 5'h08, 3);
        send(1'b0, OP_OR,  4'h3, 5'h0B, 3);
        send(1'b0, OP_NOT, 4'h0, 5'h04, 3);

        // Backpressure: consumer stalls while the next command is already valid.
        @(posedge clk); #1;
        bus.CmdValid = 1'b1;
        bus.CmdLoad  = 1'b0;
        bus.CmdOp    = OP_ADD;
        bus.CmdB     = 4'd1;
        bus.RspReady = 1'b0;
        exp_q.push_back(mk_exp(5'h05));
        @(negedge clk);
        chk("bp_ready", 32'(bus.CmdReady), 32'd1);
        @(posedge clk); #1;
        bus.CmdB = 4'd2;
        exp_q.push_back(mk_exp(5'h07));
        bad = 0;
        do begin
            @(negedge clk);
            bad++;
        end while (!bus.RspValid && bad < 20);
        chk("bp_latency", 32'(bad), 32'd3);
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid",    32'(bus.RspValid), 32'd1);
            chk("bp_rspq",     32'(bus.RspQ), 32'h05);
            chk("bp_noaccept", 32'(bus.CmdReady), 32'd0);
        end
        @(posedge clk); #1;
        bus.RspReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 32'(bus.CmdReady), 32'd1);
        chk("bp_idle_valid", 32'(bus.RspValid), 32'd0);
        @(negedge clk);
        chk("bp_next_accept", 32'(bus.CmdReady), 32'd0);
        chk("bp_next_setup",  32'({bus.AluOp, bus.AluB}), 32'({3'b111, 4'd2}));
        @(posedge clk); #1;
        bus.CmdValid = 1'b0;
        bad = 0;
        do begin
            @(negedge clk);
            bad++;
        end while (!bus.RspValid && bad < 20);
        chk("bp_second_rsp", 32'(bus.RspValid), 32'd1);

        // Reset during EXEC discards the in-flight command.
        @(posedge clk); #1;
        bus.CmdValid = 1'b1;
        bus.CmdLoad  = 1'b0;
        bus.CmdOp    = OP_ADD;
        bus.CmdB     = 4'd1;
        @(negedge clk);
        chk("rstop_ready", 32'(bus.CmdReady), 32'd1);
        @(posedge clk); #1;
        bus.CmdValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstop_exec_op", 32'(bus.AluOp), 32'(OP_ADD));
        rst_n = 1'b0;
        #1;
        chk("rstop_cmd_ready", 32'(bus.CmdReady), 32'd1);
        chk("rstop_acc",       32'(bus.Acc), 32'd0);
        chk("rstop_rsp_valid", 32'(bus.RspValid), 32'd0);
        chk("rstop_rspq",      32'(bus.RspQ), 32'd0);
        chk("rstop_aluop",     32'(bus.AluOp), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.RspValid) bad++;
        end
        chk("rstop_no_rsp", 32'(bad), 32'd0);

        // Response counter.
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 3'b000, 4'(i), {1'b0, 4'(i)}, 1);
        end
        @(posedge clk);
        @(negedge clk);
`ifdef ALU_ACC_SEQ_STAT_EN
        chk("opcount_3", 32'(bus.OpCount), 32'd3);
`else
        chk("opcount_off_3", 32'(bus.OpCount), 32'd0);
`endif
        for (int i = 3; i < 300; i++) begin
            send(1'b1, 3'b000, 4'(i), {1'b0, 4'(i)}, 1);
        end
        @(posedge clk);
        @(negedge clk);
`ifdef ALU_ACC_SEQ_STAT_EN
        chk("opcount_sat", 32'(bus.OpCount), 32'd255);
`else
        chk("opcount_off_sat", 32'(bus.OpCount), 32'd0);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
